// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the iterative multiplier.
//   mul_state_t   : IDLE / BUSY / DONE sequencer states
//   F3_*          : Funct3 encodings of the multiply operations
//   digit_bits()  : multiplier bits consumed per cycle for a given RLOG
package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    // RLOG=0 still has to consume one bit per cycle.
    function automatic int digit_bits(input int rlog);
        return (rlog < 1) ? 1 : rlog;
    endfunction

endpackage

// File: rtl/mul_iter_step.sv
// mul_iter_step: one iteration of the multiplier datapath.
//   areg     in   AW  shifted multiplicand
//   digit    in   D   current unsigned multiplier digit
//   acc      in   AW  running accumulator
//   acc_next out  AW  acc + areg*digit, modulo 2**AW
module mul_iter_step
    import mdu_pkg::*;
#(
    parameter int AW = 130,
    parameter int D  = 2
) (
    input  logic [AW-1:0] areg,
    input  logic [D-1:0]  digit,
    input  logic [AW-1:0] acc,
    output logic [AW-1:0] acc_next
);

    logic [AW-1:0] digit_w;

    assign digit_w  = {{(AW-D){1'b0}}, digit};
    assign acc_next = acc + (areg * digit_w);

endmodule

// File: rtl/mul_iter.sv
// mul_iter: iterative radix-2**RLOG multiplier producing the full 2*XLEN-bit
// product for MUL / MULH / MULHSU / MULHU.
//   clk, reset      clock, asynchronous active-low reset
//   StartE          request (taken in IDLE, or in DONE when not stalled)
//   FlushE          abort an in-flight operation (wins over StartE)
//   StallM          hold DONE and its result
//   Funct3E         operation select
//   ForwardedSrcAE  multiplicand
//   ForwardedSrcBE  multiplier
//   BusyE           iteration in progress
//   DoneM           ProdM valid (high exactly while in DONE)
//   ProdM           registered product
//   state_dbg       current sequencer state
// Handshake: StartE is sampled on a clock edge; the operation is accepted on
// the edge where the sequencer is IDLE (or DONE with StallM low) and FlushE is
// low. BusyE is then high for every iteration cycle, and DoneM rises on the
// cycle after the last one, staying high while StallM holds it.
// Build option: define MUL_EARLY_OUT_EN to leave BUSY as soon as the remaining
// multiplier bits are all zero.
module mul_iter
    import mdu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int RLOG = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StartE,
    input  logic              FlushE,
    input  logic              StallM,
    input  logic [2:0]        Funct3E,
    input  logic [XLEN-1:0]   ForwardedSrcAE,
    input  logic [XLEN-1:0]   ForwardedSrcBE,
    output logic              BusyE,
    output logic              DoneM,
    output logic [2*XLEN-1:0] ProdM,
    output mul_state_t        state_dbg
);

    localparam int D  = digit_bits(RLOG);
    localparam int N  = XLEN / D;
    localparam int CW = $clog2(N) + 1;
    localparam int AW = 2 * XLEN + 2;

    mul_state_t state, state_next;

    logic [AW-1:0]   areg, acc, acc_step, a_load, acc_load;
    logic [XLEN-1:0] breg, breg_shift;
    logic [CW-1:0]   cnt;
    logic [XLEN:0]   a_ext;
    logic            a_signed, b_signed, b_top;
    logic            start_ok, last_digit, finish;
    logic            load, step, commit;

    // Operand extension to XLEN+1 bits.
    assign a_signed = (Funct3E != F3_MULHU);
    assign b_signed = (Funct3E == F3_MULH);
    assign a_ext    = {a_signed & ForwardedSrcAE[XLEN-1], ForwardedSrcAE};
    assign b_top    = b_signed & ForwardedSrcBE[XLEN-1];
    assign a_load   = {{(XLEN+1){a_ext[XLEN]}}, a_ext};
    // The digits only cover B[XLEN-1:0]; a negative B is corrected up front
    // by preloading -A*2**XLEN, so no extra iteration is needed.
    assign acc_load = b_top ? -(a_load << XLEN) : '0;

    mul_iter_step #(.AW(AW), .D(D)) u_step (
        .areg     (areg),
        .digit    (breg[D-1:0]),
        .acc      (acc),
        .acc_next (acc_step)
    );

    assign breg_shift = breg >> D;
    assign last_digit = (cnt == CW'(N - 1));

`ifdef MUL_EARLY_OUT_EN
    // Remaining digits are all zero: the accumulator is already final.
    assign finish = last_digit | (breg_shift == '0);
`else
    assign finish = last_digit;
`endif

    assign start_ok = StartE & ~FlushE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = BUSY;
                    load       = 1'b1;
                end
            end
            BUSY: begin
                if (FlushE) begin
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (finish) begin
                        state_next = DONE;
                        commit     = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!StallM) begin
                    if (start_ok) begin
                        state_next = BUSY;
                        load       = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            areg  <= '0;
            breg  <= '0;
            acc   <= '0;
            cnt   <= '0;
            ProdM <= '0;
        end else begin
            if (load) begin
                areg <= a_load;
                breg <= ForwardedSrcBE;
                acc  <= acc_load;
                cnt  <= '0;
            end else if (step) begin
                areg <= areg << D;
                breg <= breg_shift;
                acc  <= acc_step;
                cnt  <= cnt + CW'(1);
            end
            if (commit) ProdM <= acc_step[2*XLEN-1:0];
        end
    end

    assign BusyE     = (state == BUSY);
    assign DoneM     = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter: directed checks of mul_iter (XLEN=32, RLOG=2, 16 iterations).
module tb_mul_iter;
    import mdu_pkg::*;

`ifdef MUL_EARLY_OUT_EN
    localparam int LAT_B6 = 3;
    localparam int LAT_B5 = 3;
    localparam int LAT_B3 = 2;
`else
    localparam int LAT_B6 = 17;
    localparam int LAT_B5 = 17;
    localparam int LAT_B3 = 17;
`endif
    localparam int LAT_FULL = 17;

    logic        clk;
    logic        reset;
    logic        StartE, FlushE, StallM;
    logic [2:0]  Funct3E;
    logic [31:0] ForwardedSrcAE, ForwardedSrcBE;
    logic        BusyE, DoneM;
    logic [63:0] ProdM;
    mul_state_t  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    mul_iter #(.XLEN(32), .RLOG(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .StartE         (StartE),
        .FlushE         (FlushE),
        .StallM         (StallM),
        .Funct3E        (Funct3E),
        .ForwardedSrcAE (ForwardedSrcAE),
        .ForwardedSrcBE (ForwardedSrcBE),
        .BusyE          (BusyE),
        .DoneM          (DoneM),
        .ProdM          (ProdM),
        .state_dbg      (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver: called just after a falling edge. Start is presented for one
    // cycle (cycle 0); then wait for DoneM with a cycle budget.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [63:0] exp_p, input string tag);
        int cyc;
        int busy_cycles;
        Funct3E        = f3;
        ForwardedSrcAE = a;
        ForwardedSrcBE = b;
        StartE         = 1'b1;
        @(negedge clk);
        StartE      = 1'b0;
        cyc         = 1;
        busy_cycles = 0;
        while (!DoneM && cyc < 64) begin
            if (BusyE) busy_cycles++;
            @(negedge clk);
            cyc++;
        end
        check($sformatf("%s latency", tag), 64'(cyc), 64'(exp_lat));
        check($sformatf("%s busy cycles", tag), 64'(busy_cycles), 64'(exp_lat - 1));
        check($sformatf("%s product", tag), ProdM, exp_p);
        check($sformatf("%s busy at done", tag), 64'(BusyE), 64'd0);
    endtask

    initial begin
        int done_seen;
        reset          = 1'b0;
        StartE         = 1'b0;
        FlushE         = 1'b0;
        StallM         = 1'b0;
        Funct3E        = F3_MUL;
        ForwardedSrcAE = '0;
        ForwardedSrcBE = '0;

        // reset state
        #2;
        check("reset busy", 64'(BusyE), 64'd0);
        check("reset done", 64'(DoneM), 64'd0);
        check("reset prod", ProdM, 64'd0);
        check("reset state", 64'(state_dbg), 64'(IDLE));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // main function
        run_op(F3_MUL,    32'd7,          32'd6,          LAT_B6,   64'h0000_0000_0000_002A, "mul 7x6");
        run_op(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  LAT_FULL, 64'hFFFF_FFFE_0000_0001, "mulhu max");
        run_op(F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  LAT_FULL, 64'h0000_0000_0000_0001, "mulh -1x-1");
        run_op(F3_MULH,   32'h8000_0000,  32'h8000_0000,  LAT_FULL, 64'h4000_0000_0000_0000, "mulh min");
        run_op(F3_MUL,    32'hFFFF_FFFE,  32'd3,          LAT_B3,   64'hFFFF_FFFF_FFFF_FFFA, "mul -2x3");
        run_op(F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  LAT_FULL, 64'hFFFF_FFFF_0000_0001, "mulhsu");

        // flush in cycle 5: no DoneM, ProdM keeps the previous result
        Funct3E        = F3_MUL;
        ForwardedSrcAE = 32'h1234_0000;
        ForwardedSrcBE = 32'hFFFF_FFFF;
        StartE         = 1'b1;
        @(negedge clk);
        StartE = 1'b0;
        repeat (4) @(negedge clk);
        check("flush busy before", 64'(BusyE), 64'd1);
        FlushE = 1'b1;
        @(negedge clk);
        FlushE = 1'b0;
        check("flush busy after", 64'(BusyE), 64'd0);
        check("flush state", 64'(state_dbg), 64'(IDLE));
        check("flush prod kept", ProdM, 64'hFFFF_FFFF_0000_0001);
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (DoneM) done_seen++;
        end
        check("flush no done", 64'(done_seen), 64'd0);
        run_op(F3_MUL, 32'd3, 32'd5, LAT_B5, 64'h0000_0000_0000_000F, "mul 3x5");

        // start together with flush is dropped
        @(negedge clk);
        StartE = 1'b1;
        FlushE = 1'b1;
        @(negedge clk);
        StartE = 1'b0;
        FlushE = 1'b0;
        check("start+flush busy", 64'(BusyE), 64'd0);

        // early-out candidate with StallM holding DONE for 3 cycles
        StallM = 1'b1;
        run_op(F3_MUL, 32'h1234_5678, 32'd3, LAT_B3, 64'h0000_0000_369D_0368, "mul x3 stall");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("stall done %0d", i), 64'(DoneM), 64'd1);
            check($sformatf("stall prod %0d", i), ProdM, 64'h0000_0000_369D_0368);
        end
        StallM = 1'b0;
        @(negedge clk);
        check("release done", 64'(DoneM), 64'd0);
        check("release state", 64'(state_dbg), 64'(IDLE));

        // asynchronous reset at cycle 8 of an operation
        Funct3E        = F3_MULHU;
        ForwardedSrcAE = 32'hFFFF_FFFF;
        ForwardedSrcBE = 32'hFFFF_FFFF;
        StartE         = 1'b1;
        @(negedge clk);
        StartE = 1'b0;
        repeat (7) @(negedge clk);
        check("pre-reset busy", 64'(BusyE), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("async reset busy", 64'(BusyE), 64'd0);
        check("async reset done", 64'(DoneM), 64'd0);
        check("async reset prod", ProdM, 64'd0);
        check("async reset state", 64'(state_dbg), 64'(IDLE));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post-reset busy", 64'(BusyE), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
